// File: rtl/dmem_lsu.sv
// Load/store initiator between the CPU execute stage and a word-wide data memory.
// Sub-word loads are extracted and extended; sub-word stores run read-modify-write.

module dmem_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic       is_sw,
  input  logic       is_sb,
  input  logic       is_sh,
  input  logic [1:0] addr_lo,
  input  logic [7:0] sw_byte,
  input  logic [7:0] sb_byte,
  input  logic [7:0] sh_byte,
  input  logic [7:0] old_byte,
  output logic [7:0] new_byte
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    new_byte = old_byte;
    if (is_sw)                          new_byte = sw_byte;
    else if (is_sb && addr_lo == L)     new_byte = sb_byte;
    else if (is_sh && addr_lo[1] == L[1]) new_byte = sh_byte;
  end
endmodule

module dmem_lsu #(
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic              d_ram_wena,
  output logic [MEM_AW-1:0] daddr,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out
);
  localparam int NUM_LANES = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic        misaligned;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [NUM_LANES-1:0][7:0] merged;

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = |addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Extraction works on the live memory word, captured into rdata at the RD edge.
  assign byte_sel = data_out[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? data_out[31:16] : data_out[15:0];

  always_comb begin
    load_val = data_out;
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h0, byte_sel};
      default: load_val = data_out;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      dmem_lsu_lane #(.LANE(gi)) u_lane (
        .is_sw    (op_q == OP_SW),
        .is_sb    (op_q == OP_SB),
        .is_sh    (op_q == OP_SH),
        .addr_lo  (addr_q[1:0]),
        .sw_byte  (wdata_q[8*gi +: 8]),
        .sb_byte  (wdata_q[7:0]),
        .sh_byte  (wdata_q[8*(gi%2) +: 8]),
        .old_byte (merge_q[8*gi +: 8]),
        .new_byte (merged[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata    <= 32'h0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          op_q    <= op;
          addr_q  <= addr;
          wdata_q <= wdata;
          if (misaligned) begin
            addr_err <= 1'b1;
            rdata    <= 32'h0;
            state    <= S_DONE;
          end else begin
            addr_err <= 1'b0;
            state    <= (op == OP_SW) ? S_WR : S_RD;
          end
        end
        S_RD: begin
          // op_q[2] with a load op only happens for LBU; stores are SW/SH/SB.
          if (op_q == OP_SB || op_q == OP_SH) begin
            merge_q <= data_out;
            state   <= S_WR;
          end else begin
            rdata <= load_val;
            state <= S_DONE;
          end
        end
        S_WR:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready      = (state == S_IDLE);
  assign done       = (state == S_DONE);
  assign d_ram_wena = (state == S_WR);
  assign daddr      = MEM_AW'(addr_q[31:2]);
  assign data_in    = (state == S_WR) ? merged : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboarded bench for dmem_lsu: directed loads/stores against a small word memory.
module tb_dmem_lsu;
  logic        clk = 0, rst = 1, req = 0;
  logic [2:0]  op = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        ready, done, addr_err, d_ram_wena;
  logic [31:0] rdata, daddr, data_in, data_out;

  dmem_lsu #(.MEM_AW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .addr_err(addr_err),
    .d_ram_wena(d_ram_wena), .daddr(daddr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign data_out = mem[daddr[5:0]];
  always @(posedge clk) if (d_ram_wena) mem[daddr[5:0]] <= data_in;

  typedef struct { logic [31:0] rdata; bit ck; bit err; int lat; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$], acc_hist[$];
  int   cyc = 0, wena_cnt = 0, wena_cyc = 0, last_acc = 0;
  logic [31:0] last_daddr = 0, last_din = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && req && ready) begin
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
      last_acc <= cyc;
    end
    if (d_ram_wena) begin
      wena_cnt   <= wena_cnt + 1;
      wena_cyc   <= cyc;
      last_daddr <= daddr;
      last_din   <= data_in;
    end
    cyc <= cyc + 1;
  end

  // Monitor: every completion pops one expectation and its acceptance cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("latency", cyc - a, e.lat);
        chk("addr_err", {31'h0, addr_err}, {31'h0, e.err});
        if (e.ck) chk("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] er, input bit ck, input bit e, input int lat,
                       input int nw);
    int  w0;
    bit  got;
    @(negedge clk);
    exp_q.push_back('{er, ck, e, lat});
    w0 = wena_cnt;
    op = o; addr = a; wdata = w; req = 1;
    @(posedge clk); #1 req = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL timeout waiting for done op=%0d addr=%h", o, a);
    end
    chk("wena_count", wena_cnt - w0, nw);
  endtask

  initial begin
    int w0, n0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wena", {31'h0, d_ram_wena}, 32'h0);

    // word store then load
    issue(3'b101, 32'h10, 32'hDEADBEEF, 0, 0, 0, 2, 1);
    chk("sw_daddr", last_daddr, 32'h4);
    chk("sw_wr_cycle", wena_cyc - last_acc, 32'd1);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    issue(3'b000, 32'h10, 0, 32'hDEADBEEF, 1, 0, 2, 0);

    // byte/halfword loads
    @(negedge clk); mem[4] = 32'h80FF7F01;
    issue(3'b011, 32'h10, 0, 32'h00000001, 1, 0, 2, 0);
    issue(3'b011, 32'h11, 0, 32'h0000007F, 1, 0, 2, 0);
    issue(3'b011, 32'h12, 0, 32'hFFFFFFFF, 1, 0, 2, 0);
    issue(3'b100, 32'h13, 0, 32'h00000080, 1, 0, 2, 0);
    issue(3'b001, 32'h12, 0, 32'hFFFF80FF, 1, 0, 2, 0);
    issue(3'b010, 32'h12, 0, 32'h000080FF, 1, 0, 2, 0);
    issue(3'b001, 32'h10, 0, 32'h00007F01, 1, 0, 2, 0);

    // sub-word read-modify-write
    @(negedge clk); mem[4] = 32'h11223344;
    issue(3'b111, 32'h11, 32'hAA, 0, 0, 0, 3, 1);
    chk("sb_data_in", last_din, 32'h1122AA44);
    chk("sb_wr_cycle", wena_cyc - last_acc, 32'd2);
    issue(3'b110, 32'h12, 32'hBEEF, 0, 0, 0, 3, 1);
    chk("sh_mem", mem[4], 32'hBEEFAA44);
    issue(3'b000, 32'h10, 0, 32'hBEEFAA44, 1, 0, 2, 0);

    // misaligned accesses
    issue(3'b000, 32'h11, 0, 32'h0, 1, 1, 1, 0);
    issue(3'b110, 32'h13, 32'h1234, 32'h0, 1, 1, 1, 0);
    issue(3'b001, 32'h01, 0, 32'h0, 1, 1, 1, 0);
    chk("mis_mem4", mem[4], 32'hBEEFAA44);
    chk("mis_mem0", mem[0], 32'h0);

    // request held high across a whole SB
    @(negedge clk);
    mem[5] = 32'h01020304;
    exp_q.push_back('{32'h0, 1'b0, 1'b0, 3});
    exp_q.push_back('{32'h0, 1'b0, 1'b0, 3});
    w0 = wena_cnt; n0 = acc_hist.size();
    op = 3'b111; addr = 32'h14; wdata = 32'hFF; req = 1;
    for (int i = 0; i < 20 && (acc_hist.size() - n0) < 2; i++) @(negedge clk);
    req = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("held_accepts", acc_hist.size() - n0, 32'd2);
    if (acc_hist.size() - n0 >= 2)
      chk("held_spacing", acc_hist[n0+1] - acc_hist[n0], 32'd4);
    chk("held_wena", wena_cnt - w0, 32'd2);
    chk("held_mem", mem[5], 32'h010203FF);

    // reset at the edge ending RD of an SB
    @(negedge clk);
    w0 = wena_cnt;
    op = 3'b111; addr = 32'h10; wdata = 32'h55; req = 1;
    @(posedge clk); #1 req = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    acc_q.delete();
    chk("mid_ready", {31'h0, ready}, 32'h1);
    chk("mid_done", {31'h0, done}, 32'h0);
    chk("mid_rdata", rdata, 32'h0);
    chk("mid_addr_err", {31'h0, addr_err}, 32'h0);
    chk("mid_wena", {31'h0, d_ram_wena}, 32'h0);
    chk("mid_daddr", daddr, 32'h0);
    chk("mid_data_in", data_in, 32'h0);
    repeat (3) @(negedge clk);
    chk("mid_no_write", wena_cnt - w0, 32'd0);
    chk("mid_mem", mem[4], 32'hBEEFAA44);
    issue(3'b000, 32'h10, 0, 32'hBEEFAA44, 1, 0, 2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator between the CPU execute stage and the word-wide data memory. It turns byte, halfword and word loads/stores into word-indexed memory accesses. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the memory port writes whole words only. It reports completion, and misaligned addresses, to the CPU's stall logic.

## Interface
- MEM_AW, default 32: width of the memory word-index bus `daddr`.
- clk  in  1: rising-edge clock for all state.
- rst  in  1: synchronous, active-high reset.
- req  in  1: CPU access request; sampled only while `ready`=1.
- op  in  3: access type. 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  in  32: byte address.
- wdata  in  32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- ready  out  1: unit is idle and will accept `req`.
- done  out  1: one-cycle completion pulse.
- rdata  out  32: load result; valid while `done`=1 and held until the next completion.
- addr_err  out  1: misaligned access; valid with `done`.
- d_ram_wena  out  1: memory write enable; the memory writes on the rising edge.
- daddr  out  MEM_AW: memory word index, equal to the latched addr[31:2] zero-extended.
- data_in  out  32: word to write to memory.
- data_out  in  32: memory read word; combinational (asynchronous read) from `daddr`.

## Operation
- **States:** IDLE, RD, WR, DONE.
- **IDLE** (`ready`=1). On `req`:
  - Latch op, addr and wdata.
  - Misaligned access goes to DONE with the error flagged. Misaligned means LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - SW goes to WR.
  - All other ops go to RD.
- **RD:** `daddr` is driven from the latched address and `data_out` is sampled at the clock edge.
  - For loads, the extracted result goes into `rdata`, then DONE.
  - For SB/SH, `data_out` goes into the merge register, then WR.
- **WR:** `d_ram_wena`=1 for exactly this one cycle, then DONE. `data_in` is:
  - SW: the latched wdata.
  - SB: the merge word with lane addr[1:0] replaced by wdata[7:0].
  - SH: the merge word with halfword addr[1] replaced by wdata[15:0].
- **DONE:** `done`=1 for one cycle, then IDLE. `addr_err` is 1 only for a misaligned access.
- **Byte order** is little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- **Load extraction:**
  - LB/LBU select byte lane addr[1:0].
  - LH/LHU select halfword addr[1] (0 → [15:0], 1 → [31:16]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW returns the whole word.
- **Misaligned access:** no memory cycle occurs, `d_ram_wena` never asserts, and `rdata` is driven to 0.
- **`req` outside IDLE** is ignored. The CPU holds the request until it sees `ready`.

## Timing
- Request accepted at edge E0 (req=1, ready=1). Latency:
  - LW/LH/LHU/LB/LBU: RD in cycle 1, `done` in cycle 2.
  - SW: WR in cycle 1, `done` in cycle 2.
  - SB/SH: RD in cycle 1, WR in cycle 2, `done` in cycle 3.
  - Misaligned: `done` with `addr_err` in cycle 1.
- `ready` returns to 1 in the cycle after `done`. Back-to-back requests are therefore spaced by at least 3 (load/SW) or 4 (SB/SH) cycles.
- A store is visible to a load read issued in any later request.
- **Reset** at any edge, including mid-RD or mid-WR:
  - State goes to IDLE and the in-flight access is abandoned.
  - If reset lands in WR, the memory write at that same edge still occurs (the `d_ram_wena` already applied).
  - From the next cycle all outputs take reset values: `ready`=1, `done`=0, `rdata`=0, `addr_err`=0, `d_ram_wena`=0, `daddr`=0, `data_in`=0.
- `rdata` and `addr_err` are registered. `d_ram_wena`, `daddr` and `data_in` decode from registered state only, with no combinational path from `req`.

## Test plan
- **Word store then load:** SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10.
  - Response: `daddr`=4 in WR, `d_ram_wena` high exactly 1 cycle, `done` in cycle 2.
  - LW returns `rdata`=0xDEADBEEF at cycle 2.
- **Byte loads:** memory[4]=0x80FF7F01.
  - LB addr 0x10 → 0x00000001. LB 0x12 → 0xFFFFFFFF. LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80FF. LHU 0x12 → 0x000080FF.
- **Sub-word RMW:** memory[4]=0x11223344.
  - SB addr 0x11, wdata=0xAA → `data_in`=0x1122AA44 in cycle 2, `done` in cycle 3.
  - Then SH addr 0x12, wdata=0xBEEF → memory[4]=0xBEEFAA44.
- **Misaligned:** LW 0x11, SH 0x13 and LH 0x01.
  - Each gives `done`=1 and `addr_err`=1 in cycle 1, with `rdata`=0.
  - `d_ram_wena` stays 0 and memory is unchanged.
- **Held request:** `req` held high across a whole SB.
  - Only one access executes until `ready`.
  - The second acceptance occurs at the edge after `done`.
- **Reset mid-operation:** assert `rst` at the edge ending RD of an SB.
  - No write to memory; next cycle `ready`=1 and all outputs are at their reset values.
  - Then a normal LW completes with the correct value.
